// File: rtl/uc_ctrl.sv
// rtl/uc_ctrl.sv - datapath control unit: opcode decode, HALT/resume FSM, call-stack depth guard
module uc_ctrl #(
  parameter int STACK_DEPTH = 16,
  parameter int DW          = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    opcode,
  input  logic          z,
  input  logic          resume,
  output logic          s_inc,
  output logic          s_inm,
  output logic          we3,
  output logic          wez,
  output logic          push,
  output logic          pop,
  output logic          inm,
  output logic          carry,
  output logic [2:0]    op_alu,
  output logic          halted,
  output logic [DW-1:0] depth,
  output logic          stk_ovf,
  output logic          stk_unf
);

  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [5:0]    OP_JMP  = 6'b010000;
  localparam logic [5:0]    OP_JZ   = 6'b010001;
  localparam logic [5:0]    OP_JNZ  = 6'b010010;
  localparam logic [5:0]    OP_CALL = 6'b010011;
  localparam logic [5:0]    OP_RET  = 6'b010100;
  localparam logic [5:0]    OP_HALT = 6'b010101;
  localparam logic [DW-1:0] FULL    = DW'(STACK_DEPTH);
  localparam logic [DW-1:0] ONE     = DW'(1);

  state_t        state, state_nxt;
  logic [DW-1:0] depth_q, depth_nxt;
  logic          ovf_q, unf_q, ovf_set, unf_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      depth_q <= depth_nxt;
      ovf_q   <= ovf_q | ovf_set;
      unf_q   <= unf_q | unf_set;
    end
  end

  always_comb begin
    s_inc     = 1'b1;
    s_inm     = 1'b0;
    we3       = 1'b0;
    wez       = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    op_alu    = 3'b000;
    state_nxt = state;
    depth_nxt = depth_q;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;

    if (state == HALTED) begin
      // PC stays parked on HALT until resume steps it forward
      s_inc = resume;
      if (resume) state_nxt = RUN;
    end else begin
      casez (opcode)
        6'b1?????: begin
          op_alu = opcode[4:2];
          we3    = 1'b1;
          wez    = 1'b1;
        end
        6'b0000??: begin
          we3   = 1'b1;
          s_inm = 1'b1;
        end
        OP_JMP: s_inc = 1'b0;
        OP_JZ:  s_inc = ~z;
        OP_JNZ: s_inc = z;
        OP_CALL: begin
          if (depth_q < FULL) begin
            push      = 1'b1;
            s_inc     = 1'b0;
            depth_nxt = depth_q + ONE;
          end else begin
            ovf_set = 1'b1;
          end
        end
        OP_RET: begin
          if (depth_q != '0) begin
            pop       = 1'b1;
            depth_nxt = depth_q - ONE;
          end else begin
            unf_set = 1'b1;
          end
        end
        OP_HALT: begin
          s_inc     = 1'b0;
          state_nxt = HALTED;
        end
        default: ;
      endcase
    end

    // Datapath must see a quiescent NOP for as long as reset is held
    if (!reset) begin
      s_inc  = 1'b1;
      s_inm  = 1'b0;
      we3    = 1'b0;
      wez    = 1'b0;
      push   = 1'b0;
      pop    = 1'b0;
      op_alu = 3'b000;
    end
  end

  assign inm     = 1'b0;
  assign carry   = 1'b0;
  assign halted  = (state == HALTED);
  assign depth   = depth_q;
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;

endmodule

// File: tb/tb_uc_ctrl.sv
// tb/tb_uc_ctrl.sv - scoreboard bench for uc_ctrl against a reference model
module tb_uc_ctrl;

  localparam int SD = 16;

  typedef struct packed {
    logic       s_inc, s_inm, we3, wez, push, pop, inm, carry;
    logic [2:0] op_alu;
    logic       halted;
    logic [4:0] depth;
    logic       ovf, unf;
  } exp_t;

  logic       clk, reset, z, resume;
  logic [5:0] opcode;
  logic       s_inc, s_inm, we3, wez, push, pop, inm, carry, halted, stk_ovf, stk_unf;
  logic [2:0] op_alu;
  logic [4:0] depth;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  bit   mhalt = 0;
  int   mdepth = 0;
  bit   movf = 0, munf = 0;

  uc_ctrl #(.STACK_DEPTH(SD), .DW(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .resume(resume),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .push(push), .pop(pop),
    .inm(inm), .carry(carry), .op_alu(op_alu), .halted(halted), .depth(depth),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: reset wins immediately; otherwise outputs reflect the pre-edge state
  task automatic step(input logic [5:0] op, input logic zz, input logic res, input logic rst);
    exp_t e;
    int   o;
    o = int'(op);
    @(posedge clk);
    #1;
    opcode = op; z = zz; resume = res; reset = rst;
    if (!rst) begin
      mhalt = 0; mdepth = 0; movf = 0; munf = 0;
    end
    e        = '0;
    e.s_inc  = 1'b1;
    e.halted = mhalt;
    e.depth  = 5'(mdepth);
    e.ovf    = movf;
    e.unf    = munf;
    if (rst) begin
      if (mhalt) begin
        e.s_inc = res;
        if (res) mhalt = 0;
      end else if (o >= 32) begin
        e.op_alu = 3'((o / 4) % 8);
        e.we3 = 1'b1; e.wez = 1'b1;
      end else if (o < 4) begin
        e.we3 = 1'b1; e.s_inm = 1'b1;
      end else begin
        case (o)
          16: e.s_inc = 1'b0;
          17: e.s_inc = !zz;
          18: e.s_inc = zz;
          19: if (mdepth < SD) begin e.push = 1'b1; e.s_inc = 1'b0; mdepth++; end
              else movf = 1;
          20: if (mdepth > 0) begin e.pop = 1'b1; mdepth--; end
              else munf = 1;
          21: begin e.s_inc = 1'b0; mhalt = 1; end
          default: ;
        endcase
      end
    end
    expq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(negedge clk);
      cyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = '{s_inc, s_inm, we3, wez, push, pop, inm, carry, op_alu, halted, depth, stk_ovf, stk_unf};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL ctrl cyc=%0d opcode=%b actual=%h required=%h", cyc, opcode, a, e);
        end
      end
    end
  end

  initial begin : driver
    reset = 1'b0; opcode = '0; z = 1'b0; resume = 1'b0;
    step(6'b100101, 0, 0, 0);
    step(6'b100101, 0, 0, 1);
    step(6'b010001, 1, 0, 1);
    step(6'b010001, 0, 0, 1);
    step(6'b010010, 1, 0, 1);
    step(6'b010010, 0, 0, 1);
    step(6'b000011, 0, 0, 1);
    for (int i = 0; i < SD + 1; i++) step(6'b010011, 0, 0, 1);
    step(6'b010011, 0, 0, 1);
    for (int i = 0; i < SD + 1; i++) step(6'b010100, 0, 0, 1);
    step(6'b010101, 0, 0, 1);
    step(6'b100000, 0, 0, 1);
    step(6'b010011, 0, 0, 1);
    step(6'b100000, 0, 1, 1);
    step(6'b100000, 0, 0, 1);
    step(6'b101110, 1, 1, 1);
    step(6'b010000, 0, 1, 1);
    // Build depth=5 with overflow set, park in HALTED, then async reset
    for (int i = 0; i < SD + 1; i++) step(6'b010011, 0, 0, 1);
    for (int i = 0; i < SD - 5; i++) step(6'b010100, 0, 0, 1);
    step(6'b010101, 0, 0, 1);
    step(6'b111111, 0, 0, 1);
    step(6'b111111, 0, 0, 0);
    step(6'b100101, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      logic [5:0] op;
      int r;
      r = $urandom_range(0, 9);
      if (r < 3)      op = 6'b010011;
      else if (r < 6) op = 6'b010100;
      else if (r < 7) op = 6'b010101;
      else            op = 6'($urandom_range(0, 63));
      step(op, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 79) != 0));
    end
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d pending required=0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uc_ctrl.md
Name: uc_ctrl

Overview:
- Control unit directly upstream of the single-cycle datapath.
- Consumes the datapath's `opcode[5:0]` and registered `z`. Drives every datapath control line: s_inc, s_inm, we3, wez, push, pop, inm, carry, op_alu.
- Adds sequential supervision on top of decode: a HALT/resume FSM and a call-stack depth tracker. The tracker suppresses illegal push/pop and raises sticky fault flags.

Parameters:
- STACK_DEPTH, 16, number of return-address entries in the datapath stack.
- DW, 5, width of depth counter; must satisfy 2^DW > STACK_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  INST[15:10] from datapath.
- z  in  1  registered zero flag from datapath.
- resume  in  1  single-cycle pulse; leaves HALTED.
- s_inc  out  1  1 = PC+1, 0 = DIR_SALTO.
- s_inm  out  1  1 = write immediate to register file, 0 = ALU result.
- we3  out  1  register file write enable.
- wez  out  1  zero-flag write enable.
- push  out  1  stack push (return address PC+1).
- pop  out  1  stack pop / select stack as next PC.
- inm  out  1  ALU operand-A select; always 0.
- carry  out  1  always 0.
- op_alu  out  3  ALU operation.
- halted  out  1  1 while FSM is in HALTED.
- depth  out  DW  current stack occupancy.
- stk_ovf  out  1  sticky: CALL issued at full stack.
- stk_unf  out  1  sticky: RET issued at empty stack.

Behaviour:

Decode (combinational from opcode, z, state); unlisted outputs are 0 and s_inc=1:
- 1xxxxx ALU: op_alu=opcode[4:2], we3=1, wez=1, s_inm=0. opcode[1:0] are operand bits and are ignored.
- 0000xx LOADI: we3=1, s_inm=1. opcode[1:0] are immediate bits.
- 010000 JMP: s_inc=0.
- 010001 JZ: s_inc=~z.
- 010010 JNZ: s_inc=z.
- 010011 CALL: s_inc=0, push=1.
- 010100 RET: pop=1.
- 010101 HALT: s_inc=0. Encoded as jump-to-self (DIR_SALTO = own address), so the PC parks on it.
- All other codes are NOP.

FSM states: RUN, HALTED. Reset → RUN.
- RUN, opcode=HALT → HALTED at next edge.
- HALTED: we3=wez=push=pop=0 and s_inc=0, regardless of opcode.
- HALTED with resume=1: that same cycle s_inc=1 (PC steps past HALT), all other enables 0; next state RUN.
- resume in RUN is ignored.

Depth counter, 0..STACK_DEPTH, reset 0:
- CALL in RUN with depth<STACK_DEPTH: push=1, depth+1.
- CALL with depth==STACK_DEPTH: push forced 0, s_inc forced 1 (call skipped), stk_ovf<=1, depth unchanged.
- RET in RUN with depth>0: pop=1, depth-1.
- RET with depth==0: pop forced 0, s_inc=1 (RET acts as NOP), stk_unf<=1, depth unchanged.
- stk_ovf and stk_unf clear only on reset. Execution continues after a fault.

Reset:
- Asynchronous, active-low.
- While reset=0: state=RUN, depth=0, stk_ovf=stk_unf=0, halted=0.
- While reset=0, all enables are forced 0 (we3, wez, push, pop, s_inm, inm, carry), s_inc=1, op_alu=0.
- Assertion mid-HALT or mid-call-chain discards all state.

Latency:
- Controls are valid in the same cycle as opcode. Datapath state commits at the next clk edge.
- depth, halted and fault flags update at that same edge.

Test Plan:
- Reset low, opcode=100101 → all enables 0, s_inc=1, op_alu=0. Release, same opcode → we3=1, wez=1, op_alu=3'b001, s_inm=0.
- opcode=010001, z=1 → s_inc=0. z=0 → s_inc=1. opcode=010010 inverts both. opcode=000011 → we3=1, s_inm=1, wez=0.
- 16 CALLs (STACK_DEPTH=16) → depth=16, push=1 each cycle. 17th CALL → push=0, s_inc=1, stk_ovf=1 next edge, depth stays 16. 16 RETs → depth=0. Extra RET → pop=0, stk_unf=1.
- HALT → halted=1 next edge. With opcode=100000 in HALTED → we3=0, wez=0, s_inc=0. resume pulse → s_inc=1 that cycle, halted=0 next edge.
- resume pulsed in RUN → no state change, outputs equal plain decode.
- Depth=5, stk_ovf=1, halted=1, then reset asserted asynchronously between edges → depth=0, flags=0, halted=0 immediately, without waiting for clk.
